// File: rtl/sobolrng_pkg.sv
// Shared constants and elaboration-time direction-vector builder for the Sobol generator.
// Optional scrambler elsewhere is enabled by SOBOLRNG_SCRAMBLE_EN.
package sobolrng_pkg;

    localparam int MAX_DIM   = 32'sd4;
    localparam int MAX_WIDTH = 32'sd16;

    // Primitive polynomial degree s and inner coefficients a_1..a_{s-1} (bit j-1 holds a_j).
    localparam int         POLY_DEG [MAX_DIM]    = '{32'sd0, 32'sd1, 32'sd2, 32'sd3};
    localparam logic [1:0] POLY_A   [MAX_DIM]    = '{2'b00, 2'b00, 2'b01, 2'b10};
    localparam logic [1:0] M_INIT   [MAX_DIM][3] = '{'{2'd1, 2'd0, 2'd0},
                                                     '{2'd1, 2'd0, 2'd0},
                                                     '{2'd1, 2'd3, 2'd0},
                                                     '{2'd1, 2'd3, 2'd1}};

    // Right-aligned direction vectors, [dim][k]; only the low width bits of the low width entries are meaningful.
    typedef logic [MAX_DIM-1:0][MAX_WIDTH-1:0][MAX_WIDTH-1:0] dirvec_t;

    // Built MSB-aligned in 16 bits; right shifts only drop low bits, so truncating to width is exact.
    function automatic logic [15:0] sobol_dirvec(input int dim, input int k, input int width);
        logic [15:0] v [16];
        logic [15:0] t;
        int          s;
        s = POLY_DEG[dim];
        for (int i = 0; i < 16; i++) begin
            if (dim == 0) begin
                v[i] = 16'h8000 >> i;
            end else if (i < s) begin
                v[i] = 16'(M_INIT[dim][i]) << (15 - i);
            end else begin
                t = v[i-s] ^ (v[i-s] >> s);
                for (int j = 1; j < s; j++) begin
                    if (POLY_A[dim][j-1]) begin
                        t = t ^ v[i-j];
                    end
                end
                v[i] = t;
            end
        end
        return v[k] >> (16 - width);
    endfunction

    function automatic dirvec_t sobol_dirvec_table(input int width);
        dirvec_t tbl;
        tbl = '0;
        for (int d = 0; d < MAX_DIM; d++) begin
            for (int k = 0; k < MAX_WIDTH; k++) begin
                tbl[d][k] = sobol_dirvec(d, k, width);
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/sobolrng_md_lsz_enc.sv
// Least-significant-zero priority encoder: position of the lowest 0 bit plus an all-ones flag.
module lsz_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0]                      iVal,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0] oPos,
    output logic                              oAllOnes
);
    localparam int PW = (W > 1) ? $clog2(W) : 1;

    // Scan from the top so the lowest zero bit wins.
    always_comb begin
        oPos = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!iVal[i]) begin
                oPos = PW'(i);
            end else begin
                oPos = oPos;
            end
        end
    end

    assign oAllOnes = &iVal;

endmodule

// File: rtl/sobolrng_md.sv
// Multi-dimensional Sobol generator driven by one Gray-code index counter.
// Define SOBOLRNG_SCRAMBLE_EN to add the run-time digital-shift scrambler (iScrLd/iScr).
module sobolrng_md
    import sobolrng_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int DIM      = 2
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iEn,
    input  logic                    iClr,
`ifdef SOBOLRNG_SCRAMBLE_EN
    input  logic                    iScrLd,
    input  logic [DIM*BITWIDTH-1:0] iScr,
`endif
    output logic [DIM*BITWIDTH-1:0] sobolSeq,
    output logic [BITWIDTH-1:0]     oIdx,
    output logic                    oWrap
);
    localparam int      PW      = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam dirvec_t DIR_VEC = sobol_dirvec_table(BITWIDTH);

    logic [BITWIDTH-1:0]     idx_r;
    logic [DIM*BITWIDTH-1:0] lanes_r;
    logic                    wrap_r;
    logic [PW-1:0]           cPos_s;
    logic [3:0]              cSel_s;
    logic                    allOnes_s;
    logic [DIM*BITWIDTH-1:0] stepMask_s;

    lsz_enc #(.W(BITWIDTH)) uLsz (
        .iVal     (idx_r),
        .oPos     (cPos_s),
        .oAllOnes (allOnes_s)
    );

    assign cSel_s = 4'(cPos_s);

    for (genvar d = 0; d < DIM; d++) begin : gLane
        assign stepMask_s[d*BITWIDTH +: BITWIDTH] = DIR_VEC[d][cSel_s][BITWIDTH-1:0];
    end

    // Index counter and lanes: reset, then clear, then advance or hold.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            idx_r   <= '0;
            lanes_r <= '0;
            wrap_r  <= 1'b0;
        end else if (iClr) begin
            idx_r   <= '0;
            lanes_r <= '0;
            wrap_r  <= 1'b0;
        end else if (iEn) begin
            if (allOnes_s) begin
                idx_r   <= '0;
                lanes_r <= '0;
                wrap_r  <= 1'b1;
            end else begin
                idx_r   <= idx_r + BITWIDTH'(1);
                lanes_r <= lanes_r ^ stepMask_s;
                wrap_r  <= 1'b0;
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

`ifdef SOBOLRNG_SCRAMBLE_EN
    logic [DIM*BITWIDTH-1:0] scr_r;

    // Scramble mask survives iClr so a restarted sequence keeps its shift.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            scr_r <= '0;
        end else if (iScrLd) begin
            scr_r <= iScr;
        end else begin
            scr_r <= scr_r;
        end
    end

    assign sobolSeq = lanes_r ^ scr_r;
`else
    assign sobolSeq = lanes_r;
`endif

    assign oIdx  = idx_r;
    assign oWrap = wrap_r;

endmodule

// File: tb/tb_sobolrng_md.sv
// Directed bench: table-driven 4-bit/2-dim vectors plus an 8-bit/4-dim full-period check.
module tb_sobolrng_md;

    logic       clk = 1'b0;
    logic       rst4, clr4, en4;
    logic [7:0] seq4;
    logic [3:0] idx4;
    logic       wrap4;
    logic        rst8, clr8, en8;
    logic [31:0] seq8;
    logic [7:0]  idx8;
    logic        wrap8;
`ifdef SOBOLRNG_SCRAMBLE_EN
    logic        scrLd4, scrLd8;
    logic [7:0]  scr4;
    logic [31:0] scr8;
`endif

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    sobolrng_md #(.BITWIDTH(4), .DIM(2)) dut4 (
        .iClk(clk), .iRst(rst4), .iEn(en4), .iClr(clr4),
`ifdef SOBOLRNG_SCRAMBLE_EN
        .iScrLd(scrLd4), .iScr(scr4),
`endif
        .sobolSeq(seq4), .oIdx(idx4), .oWrap(wrap4)
    );

    sobolrng_md #(.BITWIDTH(8), .DIM(4)) dut8 (
        .iClk(clk), .iRst(rst8), .iEn(en8), .iClr(clr8),
`ifdef SOBOLRNG_SCRAMBLE_EN
        .iScrLd(scrLd8), .iScr(scr8),
`endif
        .sobolSeq(seq8), .oIdx(idx8), .oWrap(wrap8)
    );

    typedef struct {
        logic       rst, clr, en;
        logic [3:0] idx, l0, l1;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];
    int   p0 [16] = '{0, 8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1};
    int   p1 [16] = '{0, 8, 4, 12, 6, 14, 2, 10, 5, 13, 1, 9, 3, 11, 7, 15};
    logic [7:0] rv [4][8];
    bit [255:0] seen [4];

    task automatic addv(input logic r, input logic c, input logic e, input int k, input logic w);
        vec_t v;
        v.rst = r; v.clr = c; v.en = e;
        v.idx = 4'(k); v.l0 = 4'(p0[k]); v.l1 = 4'(p1[k]); v.wrap = w;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] refPt(input int d, input int k);
        logic [7:0] x;
        int         g;
        x = 8'h00;
        g = k ^ (k >> 1);
        for (int j = 0; j < 8; j++) begin
            if (((g >> j) & 1) != 0) x = x ^ rv[d][j];
        end
        return x;
    endfunction

    initial begin
        rst4 = 1'b1; clr4 = 1'b0; en4 = 1'b0;
        rst8 = 1'b1; clr8 = 1'b0; en8 = 1'b0;
`ifdef SOBOLRNG_SCRAMBLE_EN
        scrLd4 = 1'b0; scr4 = 8'h00; scrLd8 = 1'b0; scr8 = 32'h0;
`endif

        // Vector table: reset, run, enable gap, wrap, clear, reset+clear.
        addv(1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 7; k++) addv(1'b0, 1'b0, 1'b1, k, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 7, 1'b0);
        addv(1'b0, 1'b0, 1'b0, 7, 1'b0);
        for (int k = 8; k <= 15; k++) addv(1'b0, 1'b0, 1'b1, k, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 0, 1'b1);
        for (int k = 1; k <= 5; k++) addv(1'b0, 1'b0, 1'b1, k, 1'b0);
        addv(1'b0, 1'b1, 1'b1, 0, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 1, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 2, 1'b0);
        addv(1'b1, 1'b1, 1'b1, 0, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 1, 1'b0);
        addv(1'b0, 1'b0, 1'b1, 2, 1'b0);
        addv(1'b0, 1'b1, 1'b0, 0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst4 = vecs[i].rst; clr4 = vecs[i].clr; en4 = vecs[i].en;
            @(posedge clk); #1;
            nVec++;
            if ({idx4, seq4[3:0], seq4[7:4], wrap4} !== {vecs[i].idx, vecs[i].l0, vecs[i].l1, vecs[i].wrap}) begin
                nErr++;
                $display("FAIL vec%0d: got idx=%0d l0=%0d l1=%0d wrap=%0b expected idx=%0d l0=%0d l1=%0d wrap=%0b",
                         i, idx4, seq4[3:0], seq4[7:4], wrap4,
                         vecs[i].idx, vecs[i].l0, vecs[i].l1, vecs[i].wrap);
            end
        end
        rst4 = 1'b0; clr4 = 1'b0; en4 = 1'b0;

`ifdef SOBOLRNG_SCRAMBLE_EN
        // Scrambled lane 0: mask 5 gives 5,13,9,1; clear keeps mask, reset drops it.
        scrLd4 = 1'b1; scr4 = 8'h05; clr4 = 1'b1;
        @(posedge clk); #1;
        chk("scr_p0", {56'h0, seq4}, 64'h05);
        scrLd4 = 1'b0; clr4 = 1'b0; en4 = 1'b1;
        @(posedge clk); #1;
        chk("scr_p1", {56'h0, seq4}, 64'h8D);
        @(posedge clk); #1;
        chk("scr_p2", {56'h0, seq4}, 64'h49);
        @(posedge clk); #1;
        chk("scr_p3", {56'h0, seq4}, 64'hC1);
        en4 = 1'b0; clr4 = 1'b1;
        @(posedge clk); #1;
        chk("scr_clr", {56'h0, seq4}, 64'h05);
        clr4 = 1'b0; rst4 = 1'b1;
        @(posedge clk); #1;
        chk("scr_rst", {56'h0, seq4}, 64'h00);
        rst4 = 1'b0;
`endif

        // Independent 8-bit reference direction vectors.
        for (int j = 0; j < 8; j++) begin
            rv[0][j] = 8'h80 >> j;
            if (j == 0) rv[1][j] = 8'h80;
            else        rv[1][j] = rv[1][j-1] ^ (rv[1][j-1] >> 1);
            if (j == 0)      rv[2][j] = 8'h80;
            else if (j == 1) rv[2][j] = 8'hC0;
            else             rv[2][j] = rv[2][j-1] ^ rv[2][j-2] ^ (rv[2][j-2] >> 2);
            if (j == 0)      rv[3][j] = 8'h80;
            else if (j == 1) rv[3][j] = 8'hC0;
            else if (j == 2) rv[3][j] = 8'h20;
            else             rv[3][j] = rv[3][j-2] ^ rv[3][j-3] ^ (rv[3][j-3] >> 3);
        end

        @(posedge clk); #1;
        chk("rst8", {23'h0, seq8, idx8, wrap8}, 64'h0);
        for (int d = 0; d < 4; d++) seen[d] = '0;
        for (int d = 0; d < 4; d++) seen[d][seq8[d*8 +: 8]] = 1'b1;
        rst8 = 1'b0; en8 = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            logic [31:0] expSeq;
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) expSeq[d*8 +: 8] = refPt(d, k % 256);
            nVec++;
            if ({seq8, idx8, wrap8} !== {expSeq, 8'(k % 256), (k == 256)}) begin
                nErr++;
                $display("FAIL full8 k=%0d: got seq=%08h idx=%0d wrap=%0b expected seq=%08h idx=%0d wrap=%0b",
                         k, seq8, idx8, wrap8, expSeq, k % 256, (k == 256));
            end
            if (k < 256) begin
                for (int d = 0; d < 4; d++) seen[d][seq8[d*8 +: 8]] = 1'b1;
            end
        end
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("perm8_d%0d", d), {63'h0, &seen[d]}, 64'h1);
        end
        @(posedge clk); #1;
        chk("wrap8_once", {63'h0, wrap8}, 64'h0);
        en8 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/sobolrng_md.md
Name: sobolrng_md

Overview:
- Multi-dimensional, width-parametrised Sobol low-discrepancy sequence generator; next generation of the single-dimension sobolrng.
- Emits DIM decorrelated Sobol streams per enabled cycle from one shared Gray-code index counter.
- Feeds unary/stochastic bitstream generators, which compare each stream against a binary operand.
- Adds a period-wrap pulse and an index output; an optional run-time digital-shift scrambler is compiled in by macro.

Parameters:
- BITWIDTH, 8, bits per stream and counter width; legal 2..16; period 2^BITWIDTH.
- DIM, 2, number of Sobol dimensions; legal 1..4.

Ports:
- iClk  in  1  clock; one clock domain, rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iEn  in  1  advance one point per cycle while high.
- iClr  in  1  synchronous restart of sequence to point 0.
- sobolSeq  out  DIM*BITWIDTH  packed streams; dimension d occupies bits [d*BITWIDTH +: BITWIDTH].
- oIdx  out  BITWIDTH  index of the point currently on sobolSeq.
- oWrap  out  1  one-cycle pulse on the first point after a period completes.

Behaviour:
- Reset (iRst=1): oIdx=0, every sobolSeq lane=0, oWrap=0. Reset overrides iClr and iEn.
- Priority order: iRst, then iClr, then iEn.
- iClr=1 (no reset): next cycle oIdx=0, all lanes 0, oWrap=0, whatever iEn is.
- iEn=0: all state holds; oWrap=0.
- Advance step (iEn=1, iClr=0):
  - c = least-significant-zero position of oIdx (0..BITWIDTH-1).
  - Each lane d: lane_d <= lane_d XOR V[d][c].
  - oIdx <= oIdx+1.
- Wrap (oIdx all-ones, so no zero bit exists): oIdx<=0, all lanes<=0, oWrap<=1 for that single cycle.
- Latency: outputs are registered; point k appears exactly k enabled cycles after clear or reset.
- Enable gaps do not skip or repeat points.
- Direction vectors, v_0 = 1 in the MSB:
  - d0: v_k = MSB>>k (van der Corput).
  - d1: polynomial x+1: v_k = v_{k-1}^(v_{k-1}>>1).
  - d2: x^2+x+1, m=1,3: v_k = v_{k-1}^v_{k-2}^(v_{k-2}>>2).
  - d3: x^3+x+1, m=1,3,1: v_k = v_{k-2}^v_{k-3}^(v_{k-3}>>3).
- Direction vectors are constant: computed at elaboration, never stored in flops.
- Selecting c: priority encoder over ~oIdx; V[d][c] is picked by a mux.

Optional Feature:
- Macro: SOBOLRNG_SCRAMBLE_EN.
- With macro:
  - Extra ports: iScrLd in 1; iScr in DIM*BITWIDTH.
  - Scramble register loads iScr when iScrLd=1; reset value 0; unaffected by iClr.
  - sobolSeq = internal lanes XOR scramble register (combinational after the flops).
  - A load takes effect on the next cycle.
- Without macro: ports absent; sobolSeq = internal lanes.

Decomposition:
- Package sobolrng_pkg holds:
  - MAX_DIM=4.
  - Polynomial degree and coefficient constants per dimension.
  - Function sobol_dirvec(dim, k, width) returning v_k.
  - Typedef for the direction-vector array.
- Sub-module lsz_enc (least-significant-zero priority encoder, BITWIDTH-parametrised, outputs index plus all-ones flag); one instance.

Test Plan:
- BITWIDTH=4, DIM=2, reset then iEn=1 -> d0 lane 0,8,12,4,6,14,10,2; d1 lane 0,8,4,12,6,14,2,10; oIdx 0..7.
- Run 16 enabled cycles from 0 -> on the 16th edge oIdx=0, lanes=0, oWrap=1 for exactly one cycle. Over the period every lane visits each of 0..15 exactly once.
- iEn toggled 1,0,0,1 -> the sequence continues with no skipped or repeated points; oWrap stays 0.
- iClr asserted at oIdx=5 with iEn=1 -> next cycle oIdx=0 and lanes 0. Then iRst and iClr together -> reset result, and the sequence restarts at point 0.
- BITWIDTH=8, DIM=4, full 256-point period -> each lane is a permutation of 0..255; lanes match a reference-model Sobol generator.
- With SOBOLRNG_SCRAMBLE_EN, BITWIDTH=4, iScr lane0=0x5 loaded -> d0 outputs 5,13,9,1 at points 0..3. iClr leaves the mask intact; iRst clears it.
